time_cmd_ctrl: RTL and testbench

TIME_CMD_CTRL -- requirements
Module: time_cmd_ctrl

---
 rtl/clock_pkg.sv | 30 +++
 rtl/ascii_bcd_decode.sv | 12 +
 rtl/time_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_time_cmd_ctrl.sv | 575 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and types for the clock command front end.
// ASCII command bytes, BCD range limits and the command FSM state type.
package clock_pkg;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_T  = 8'h54;
    localparam logic [7:0] ASC_P  = 8'h50;
    localparam logic [7:0] ASC_S  = 8'h53;
    localparam logic [7:0] ASC_G  = 8'h47;
    localparam logic [7:0] ASC_K  = 8'h4B;
    localparam logic [7:0] ASC_E  = 8'h45;

    localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
    localparam logic [7:0] BCD_MS_MAX   = 8'h59;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_WAIT_CR,
        ST_FLUSH,
        ST_EXEC,
        ST_REPLY
    } state_t;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nib);
        return {4'h3, nib};
    endfunction

endpackage

// File: rtl/ascii_bcd_decode.sv
// ASCII digit decoder: flags '0'..'9' and yields the BCD nibble.
// Ports: ch (byte in), is_digit (ch is a decimal digit), nibble (low 4 bits).
module ascii_bcd_decode (
    input  logic [7:0] ch,
    output logic       is_digit,
    output logic [3:0] nibble
);

    assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
    assign nibble   = ch[3:0];

endmodule

// File: rtl/time_cmd_ctrl.sv
// UART command parser for the clock: T/P/S/G commands, replies, errors.
// Ports: clk/rst, rx byte stream in, tx byte stream out (valid/ready),
// cur_* live BCD time in, set_* + set_valid load, pause/speed strobes,
// err_count saturating reject counter.
module time_cmd_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] cur_hours,
    input  logic [7:0] cur_minutes,
    input  logic [7:0] cur_seconds,
    output logic [7:0] set_hours,
    output logic [7:0] set_minutes,
    output logic [7:0] set_seconds,
    output logic       set_valid,
    output logic       pause_toggle,
    output logic       speed_toggle,
    output logic [7:0] err_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [7:0]    cmd;
    logic [23:0]   digits;
    logic [2:0]    dcnt;
    logic [TW-1:0] tmr;
    logic [47:0]   rbuf;
    logic [2:0]    rcnt;

    logic       is_digit;
    logic [3:0] nib;
    logic       is_cr;
    logic       in_cmd;
    logic       timeout;
    logic       range_ok;
    logic       err_evt;
    logic       drop;
    logic [8:0] err_sum;

    ascii_bcd_decode u_dec (
        .ch       (rx_data),
        .is_digit (is_digit),
        .nibble   (nib)
    );

    assign is_cr  = (rx_data == ASC_CR);
    assign in_cmd = (state == ST_ARGS) ||
                    (state == ST_WAIT_CR) ||
                    (state == ST_FLUSH);
    // Idle gap counter hits its last value with no byte this cycle.
    assign timeout = in_cmd && !rx_valid && (tmr == TMR_LAST);

    assign range_ok = (digits[23:16] <= BCD_HOUR_MAX) &&
                      (digits[15:8]  <= BCD_MS_MAX) &&
                      (digits[7:0]   <= BCD_MS_MAX);

    assign set_hours   = digits[23:16];
    assign set_minutes = digits[15:8];
    assign set_seconds = digits[7:0];

    // Every path that ends in an 'E' reply raises err_evt exactly once.
    always_comb begin
        err_evt = 1'b0;
        unique case (state)
            ST_ARGS, ST_FLUSH: err_evt = timeout || (rx_valid && is_cr);
            ST_WAIT_CR:        err_evt = timeout;
            ST_EXEC:           err_evt = (cmd == ASC_T) && !range_ok;
            default:           err_evt = 1'b0;
        endcase
    end

    assign drop = rx_valid && ((state == ST_EXEC) || (state == ST_REPLY));

    // An 'E' reply and a dropped byte can coincide in EXEC.
    assign err_sum = {1'b0, err_count} + {8'h00, err_evt} + {8'h00, drop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else begin
            err_count <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cmd          <= '0;
            digits       <= '0;
            dcnt         <= '0;
            tmr          <= '0;
            rbuf         <= '0;
            rcnt         <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            set_valid    <= 1'b0;
            pause_toggle <= 1'b0;
            speed_toggle <= 1'b0;
        end else begin
            set_valid    <= 1'b0;
            pause_toggle <= 1'b0;
            speed_toggle <= 1'b0;

            if (in_cmd) begin
                tmr <= rx_valid ? '0 : tmr + 1'b1;
            end

            if (timeout) begin
                state    <= ST_REPLY;
                tx_valid <= 1'b1;
                tx_data  <= ASC_E;
                rcnt     <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (rx_valid) begin
                            tmr <= '0;
                            cmd <= rx_data;
                            unique case (1'b1)
                                (rx_data == ASC_LF): ;
                                (rx_data == ASC_T): begin
                                    dcnt  <= '0;
                                    state <= ST_ARGS;
                                end
                                (rx_data == ASC_P),
                                (rx_data == ASC_S),
                                (rx_data == ASC_G): state <= ST_WAIT_CR;
                                default: state <= ST_FLUSH;
                            endcase
                        end
                    end
                    ST_ARGS: begin
                        if (rx_valid) begin
                            if (is_digit) begin
                                digits <= {digits[19:0], nib};
                                dcnt   <= dcnt + 1'b1;
                                if (dcnt == 3'd5) begin
                                    state <= ST_WAIT_CR;
                                end
                            end else if (is_cr) begin
                                state    <= ST_REPLY;
                                tx_valid <= 1'b1;
                                tx_data  <= ASC_E;
                                rcnt     <= '0;
                            end else begin
                                state <= ST_FLUSH;
                            end
                        end
                    end
                    ST_WAIT_CR: begin
                        if (rx_valid) begin
                            if (is_cr) begin
                                state <= ST_EXEC;
                                // Strobes are registered so they are high
                                // during the single EXEC cycle.
                                unique case (1'b1)
                                    (cmd == ASC_T): set_valid    <= range_ok;
                                    (cmd == ASC_P): pause_toggle <= 1'b1;
                                    (cmd == ASC_S): speed_toggle <= 1'b1;
                                    default: ;
                                endcase
                            end else begin
                                state <= ST_FLUSH;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (rx_valid && is_cr) begin
                            state    <= ST_REPLY;
                            tx_valid <= 1'b1;
                            tx_data  <= ASC_E;
                            rcnt     <= '0;
                        end
                    end
                    ST_EXEC: begin
                        state    <= ST_REPLY;
                        tx_valid <= 1'b1;
                        rcnt     <= '0;
                        if (cmd == ASC_G) begin
                            tx_data <= bcd_to_ascii(cur_hours[7:4]);
                            rbuf    <= {bcd_to_ascii(cur_hours[3:0]),
                                        bcd_to_ascii(cur_minutes[7:4]),
                                        bcd_to_ascii(cur_minutes[3:0]),
                                        bcd_to_ascii(cur_seconds[7:4]),
                                        bcd_to_ascii(cur_seconds[3:0]),
                                        ASC_CR};
                            rcnt    <= 3'd6;
                        end else if (cmd == ASC_T && !range_ok) begin
                            tx_data <= ASC_E;
                        end else begin
                            tx_data <= ASC_K;
                        end
                    end
                    ST_REPLY: begin
                        if (tx_ready) begin
                            if (rcnt == 3'd0) begin
                                tx_valid <= 1'b0;
                                tx_data  <= '0;
                                state    <= ST_IDLE;
                            end else begin
                                tx_data <= rbuf[47:40];
                                rbuf    <= {rbuf[39:0], 8'h00};
                                rcnt    <= rcnt - 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_time_cmd_ctrl.sv
// Testbench for time_cmd_ctrl: directed scenarios plus random commands
// checked against a string-level reference model.
module tb_time_cmd_ctrl;

    localparam int TO = 50;

    typedef logic [7:0] bq_t[$];

    localparam logic [7:0] C_CR = 8'h0D;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] cur_hours;
    logic [7:0] cur_minutes;
    logic [7:0] cur_seconds;
    logic [7:0] set_hours;
    logic [7:0] set_minutes;
    logic [7:0] set_seconds;
    logic       set_valid;
    logic       pause_toggle;
    logic       speed_toggle;
    logic [7:0] err_count;

    time_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .cur_seconds  (cur_seconds),
        .set_hours    (set_hours),
        .set_minutes  (set_minutes),
        .set_seconds  (set_seconds),
        .set_valid    (set_valid),
        .pause_toggle (pause_toggle),
        .speed_toggle (speed_toggle),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;
    int ready_mode = 1;

    // 0: hold low, 1: hold high, 2: random per cycle
    always @(posedge clk) begin
        #1;
        if (ready_mode == 2) tx_ready = 1'($urandom_range(0, 1));
        else tx_ready = (ready_mode == 1);
    end

    bq_t        tx_log;
    int         sv_cnt = 0;
    int         pt_cnt = 0;
    int         st_cnt = 0;
    int         multi_cnt = 0;
    logic [23:0] sv_last = '0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (tx_valid && tx_ready) tx_log.push_back(tx_data);
            if (set_valid) begin
                sv_cnt++;
                sv_last = {set_hours, set_minutes, set_seconds};
            end
            if (pause_toggle) pt_cnt++;
            if (speed_toggle) st_cnt++;
            if (int'(set_valid) + int'(pause_toggle) + int'(speed_toggle) > 1)
                multi_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic send_q(input bq_t q, input int gap);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (gap > 0) tick($urandom_range(0, gap));
        end
    endtask

    function automatic bq_t str2q(input string s, input bit add_cr);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        if (add_cr) q.push_back(C_CR);
        return q;
    endfunction

    function automatic logic [63:0] pack(input bq_t q, input int start);
        logic [63:0] p;
        p = '0;
        for (int i = start; i < q.size(); i++) p = {p[55:0], q[i]};
        return p;
    endfunction

    task automatic wait_tx(input int upto, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tx_log.size() >= upto) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        for (int i = 0; i < 400; i++) begin
            if (!tx_valid) break;
            tick(1);
        end
        tick(1);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_err = 0;
        tick(1);
    endtask

    function automatic void bump_err();
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    endfunction

    // Reference: whole command string in, reply bytes and effects out.
    function automatic void model(input bq_t q, input logic [23:0] cur,
                                  output bq_t rep, output int dsv,
                                  output int dpt, output int dst,
                                  output logic [23:0] sv, output bit eflag);
        int  v[6];
        bit  alld;
        int  hh, mm, ss;
        rep.delete();
        dsv = 0; dpt = 0; dst = 0; sv = '0; eflag = 1'b1;
        if (q.size() == 8 && q[0] == "T" && q[7] == C_CR) begin
            alld = 1'b1;
            for (int i = 1; i <= 6; i++) begin
                if (q[i] < "0" || q[i] > "9") alld = 1'b0;
                else v[i-1] = int'(q[i]) - 48;
            end
            if (alld) begin
                hh = v[0] * 10 + v[1];
                mm = v[2] * 10 + v[3];
                ss = v[4] * 10 + v[5];
                if (hh <= 23 && mm <= 59 && ss <= 59) begin
                    eflag = 1'b0;
                    dsv = 1;
                    sv = {4'(v[0]), 4'(v[1]), 4'(v[2]),
                          4'(v[3]), 4'(v[4]), 4'(v[5])};
                    rep.push_back("K");
                end
            end
        end else if (q.size() == 2 && q[1] == C_CR) begin
            if (q[0] == "P") begin
                eflag = 1'b0; dpt = 1; rep.push_back("K");
            end else if (q[0] == "S") begin
                eflag = 1'b0; dst = 1; rep.push_back("K");
            end else if (q[0] == "G") begin
                eflag = 1'b0;
                for (int k = 5; k >= 0; k--)
                    rep.push_back(8'h30 + {4'h0, cur[k*4 +: 4]});
                rep.push_back(C_CR);
            end
        end
        if (eflag) rep.push_back("E");
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx got v=%b d=%h exp v=0 d=00", tx_valid, tx_data);
        end
        checks++;
        if ({set_valid, pause_toggle, speed_toggle} !== 3'b000 ||
            {set_hours, set_minutes, set_seconds} !== 24'h0) begin
            errors++;
            $display("FAIL reset_strobes got %b %h exp 000 000000",
                     {set_valid, pause_toggle, speed_toggle},
                     {set_hours, set_minutes, set_seconds});
        end
        checks++;
        if (err_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_err got %0d exp 0", err_count);
        end
        rst = 1'b0;
        exp_err = 0;
        tick(1);
    endtask

    task automatic test_set_time();
        int start = tx_log.size();
        int s0 = sv_cnt;
        bit ok;
        send_q(str2q("T123456", 1), 0);
        wait_tx(start + 1, ok);
        checks++;
        if (!ok || tx_log[start] !== "K") begin
            errors++;
            $display("FAIL set_reply got ok=%b %h exp 4b", ok,
                     ok ? tx_log[start] : 8'hxx);
        end
        checks++;
        if (sv_cnt - s0 != 1) begin
            errors++;
            $display("FAIL set_pulses got %0d exp 1", sv_cnt - s0);
        end
        checks++;
        if (sv_last !== 24'h123456) begin
            errors++;
            $display("FAIL set_value got %h exp 123456", sv_last);
        end
        checks++;
        if (int'(err_count) != exp_err) begin
            errors++;
            $display("FAIL set_err got %0d exp %0d", err_count, exp_err);
        end
    endtask

    task automatic test_range_err();
        int start = tx_log.size();
        int s0 = sv_cnt;
        bit ok;
        send_q(str2q("T245900", 1), 0);
        bump_err();
        wait_tx(start + 1, ok);
        checks++;
        if (!ok || tx_log[start] !== "E") begin
            errors++;
            $display("FAIL range_reply got ok=%b exp 45", ok);
        end
        checks++;
        if (sv_cnt != s0) begin
            errors++;
            $display("FAIL range_no_set got %0d pulses exp 0", sv_cnt - s0);
        end
        checks++;
        if (err_count !== 8'd1 || int'(err_count) != exp_err) begin
            errors++;
            $display("FAIL range_err got %0d exp 1", err_count);
        end
    endtask

    task automatic test_get_stall();
        int start;
        bit ok;
        bit stable = 1'b1;
        logic [7:0] first;
        cur_hours = 8'h09; cur_minutes = 8'h05; cur_seconds = 8'h07;
        ready_mode = 0;
        tick(2);
        start = tx_log.size();
        send_q(str2q("G", 1), 0);
        wait_valid(ok);
        first = tx_data;
        repeat (10) begin
            tick(1);
            if (!tx_valid || tx_data !== first) stable = 1'b0;
        end
        checks++;
        if (!ok || first !== "0") begin
            errors++;
            $display("FAIL get_first got ok=%b %h exp 30", ok, first);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL get_stall got v=%b d=%h exp v=1 d=%h", tx_valid, tx_data, first);
        end
        ready_mode = 1;
        wait_tx(start + 7, ok);
        checks++;
        if (!ok || tx_log.size() - start != 7 ||
            pack(tx_log, start) !== 64'h00_30_39_30_35_30_37_0D) begin
            errors++;
            $display("FAIL get_reply got %h exp 0030393035303 70d", pack(tx_log, start));
        end
        checks++;
        if (int'(err_count) != exp_err) begin
            errors++;
            $display("FAIL get_err got %0d exp %0d", err_count, exp_err);
        end
    endtask

    task automatic test_timeout();
        int start = tx_log.size();
        int n = 0;
        int p0 = pt_cnt;
        bit ok;
        ready_mode = 0;
        send_q(str2q("T12", 0), 0);
        while (!tx_valid && n < 200) begin
            tick(1);
            n++;
        end
        bump_err();
        checks++;
        if (n < TO || n > TO + 1) begin
            errors++;
            $display("FAIL timeout_cycles got %0d exp %0d", n, TO);
        end
        checks++;
        if (tx_data !== "E") begin
            errors++;
            $display("FAIL timeout_data got %h exp 45", tx_data);
        end
        ready_mode = 1;
        wait_tx(start + 1, ok);
        checks++;
        if (!ok || int'(err_count) != exp_err) begin
            errors++;
            $display("FAIL timeout_err got %0d exp %0d", err_count, exp_err);
        end
        start = tx_log.size();
        send_q(str2q("P", 1), 0);
        wait_tx(start + 1, ok);
        checks++;
        if (pt_cnt - p0 != 1) begin
            errors++;
            $display("FAIL pause_pulse got %0d exp 1", pt_cnt - p0);
        end
        checks++;
        if (!ok || tx_log[start] !== "K") begin
            errors++;
            $display("FAIL pause_reply got ok=%b exp 4b", ok);
        end
    endtask

    task automatic test_flush_drop();
        int start;
        int s0;
        bit ok;
        reset_dut();
        s0 = st_cnt;
        start = tx_log.size();
        ready_mode = 0;
        send_q(str2q("X12", 1), 0);
        bump_err();
        wait_valid(ok);
        send_byte("S");
        bump_err();
        tick(1);
        ready_mode = 1;
        wait_tx(start + 1, ok);
        checks++;
        if (!ok || tx_log.size() - start != 1 || tx_log[start] !== "E") begin
            errors++;
            $display("FAIL flush_reply got ok=%b n=%0d exp E", ok, tx_log.size() - start);
        end
        checks++;
        if (err_count !== 8'd2 || int'(err_count) != exp_err) begin
            errors++;
            $display("FAIL flush_err got %0d exp 2", err_count);
        end
        checks++;
        if (st_cnt != s0) begin
            errors++;
            $display("FAIL flush_no_speed got %0d exp 0", st_cnt - s0);
        end
    endtask

    task automatic test_reset_mid_reply();
        int start;
        int s0;
        bit ok;
        cur_hours = 8'h21; cur_minutes = 8'h43; cur_seconds = 8'h58;
        ready_mode = 0;
        send_q(str2q("G", 1), 0);
        wait_valid(ok);
        tick(1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (!ok || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_tx got ok=%b v=%b d=%h exp v=0 d=00", ok, tx_valid, tx_data);
        end
        checks++;
        if (err_count !== 8'h00) begin
            errors++;
            $display("FAIL midreset_err got %0d exp 0", err_count);
        end
        ready_mode = 1;
        tick(2);
        rst = 1'b0;
        exp_err = 0;
        tick(1);
        s0 = st_cnt;
        start = tx_log.size();
        send_q(str2q("S", 1), 0);
        wait_tx(start + 1, ok);
        checks++;
        if (st_cnt - s0 != 1) begin
            errors++;
            $display("FAIL midreset_speed got %0d exp 1", st_cnt - s0);
        end
        checks++;
        if (!ok || tx_log.size() - start != 1 || tx_log[start] !== "K") begin
            errors++;
            $display("FAIL midreset_reply got ok=%b n=%0d exp K", ok, tx_log.size() - start);
        end
    endtask

    task automatic test_random();
        string junk = "ABXYZ";
        bq_t q;
        bq_t rep;
        int dsv, dpt, dst, k, n;
        int start, s0, p0, t0;
        logic [23:0] sv;
        logic [23:0] cur;
        bit eflag, ok;
        ready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            q.delete();
            cur = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                   4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                   4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            cur_hours = cur[23:16]; cur_minutes = cur[15:8]; cur_seconds = cur[7:0];
            k = $urandom_range(0, 6);
            case (k)
                0: begin
                    q.push_back("T");
                    q.push_back(8'h30 + 8'($urandom_range(0, 2)));
                    q.push_back(8'h30 + 8'($urandom_range(0, 9)));
                    q.push_back(8'h30 + 8'($urandom_range(0, 6)));
                    q.push_back(8'h30 + 8'($urandom_range(0, 9)));
                    q.push_back(8'h30 + 8'($urandom_range(0, 6)));
                    q.push_back(8'h30 + 8'($urandom_range(0, 9)));
                    q.push_back(C_CR);
                end
                1: q = str2q("P", 1);
                2: q = str2q("S", 1);
                3: q = str2q("G", 1);
                4: begin
                    q.push_back("T");
                    n = $urandom_range(0, 5);
                    repeat (n) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
                    q.push_back(C_CR);
                end
                5: begin
                    q.push_back(junk[$urandom_range(0, 4)]);
                    n = $urandom_range(0, 3);
                    repeat (n) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
                    q.push_back(C_CR);
                end
                default: q = str2q("PQ", 1);
            endcase
            model(q, cur, rep, dsv, dpt, dst, sv, eflag);
            if (eflag) bump_err();
            start = tx_log.size();
            s0 = sv_cnt; p0 = pt_cnt; t0 = st_cnt;
            send_q(q, 3);
            wait_tx(start + rep.size(), ok);
            checks++;
            if (!ok || tx_log.size() - start != rep.size() ||
                pack(tx_log, start) !== pack(rep, 0)) begin
                errors++;
                $display("FAIL rand_reply_%0d got %h n=%0d exp %h n=%0d", it,
                         pack(tx_log, start), tx_log.size() - start,
                         pack(rep, 0), rep.size());
            end
            checks++;
            if (sv_cnt - s0 != dsv || pt_cnt - p0 != dpt || st_cnt - t0 != dst) begin
                errors++;
                $display("FAIL rand_strobes_%0d got %0d/%0d/%0d exp %0d/%0d/%0d", it,
                         sv_cnt - s0, pt_cnt - p0, st_cnt - t0, dsv, dpt, dst);
            end
            if (dsv == 1) begin
                checks++;
                if (sv_last !== sv) begin
                    errors++;
                    $display("FAIL rand_setval_%0d got %h exp %h", it, sv_last, sv);
                end
            end
            checks++;
            if (int'(err_count) != exp_err) begin
                errors++;
                $display("FAIL rand_err_%0d got %0d exp %0d", it, err_count, exp_err);
            end
        end
        checks++;
        if (multi_cnt != 0) begin
            errors++;
            $display("FAIL strobe_onehot got %0d overlaps exp 0", multi_cnt);
        end
        ready_mode = 1;
        tick(2);
    endtask

    task automatic test_saturation();
        int start;
        bit ok;
        reset_dut();
        ready_mode = 1;
        for (int i = 0; i < 258; i++) begin
            start = tx_log.size();
            send_q(str2q("E", 1), 0);
            bump_err();
            wait_tx(start + 1, ok);
            if (i == 253) begin
                checks++;
                if (!ok || int'(err_count) != exp_err || err_count !== 8'd254) begin
                    errors++;
                    $display("FAIL sat_254 got %0d exp 254", err_count);
                end
            end
        end
        checks++;
        if (err_count !== 8'd255 || exp_err != 255) begin
            errors++;
            $display("FAIL sat_hold got %0d exp 255", err_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        cur_hours = '0;
        cur_minutes = '0;
        cur_seconds = '0;
        test_reset();
        test_set_time();
        test_range_err();
        test_get_stall();
        test_timeout();
        test_flush_drop();
        test_reset_mid_reply();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
